// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide,
// one iteration per clock, with HI/LO result registers and MTHI/MTLO writes.
module muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned W2   = 2 * WIDTH;
  localparam int unsigned CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;   // negate product / quotient
  logic             neg_hi_q, neg_hi_d;   // negate remainder (sign of dividend)
  logic             bzero_q, bzero_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic [WIDTH-1:0] b_mag_q, b_mag_d;     // multiplicand / divisor magnitude
  logic [WIDTH-1:0] acc_q, acc_d;         // product high half / partial remainder
  logic [WIDTH-1:0] work_q, work_d;       // multiplier shifting out / quotient shifting in
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Operand magnitudes; signs only matter for the signed ops (op[0]=1)
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg = op[0] & A[WIDTH-1];
  assign b_neg = op[0] & B[WIDTH-1];
  assign a_mag = a_neg ? WIDTH'(~A + WIDTH'(1)) : A;
  assign b_mag = b_neg ? WIDTH'(~B + WIDTH'(1)) : B;

  // One shift-add multiply step: conditional add, then shift {acc,work} right
  logic [WIDTH:0] msum;
  assign msum = {1'b0, acc_q} + (work_q[0] ? {1'b0, b_mag_q} : {(WIDTH+1){1'b0}});

  // One restoring divide step: trial subtract of the shifted partial remainder
  logic [WIDTH:0] trial;
  assign trial = {acc_q, work_q[WIDTH-1]} - {1'b0, b_mag_q};

  // Final sign correction of the raw magnitudes
  logic [W2-1:0]    prod_raw, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  assign prod_raw = {acc_q, work_q};
  assign prod_fix = neg_lo_q ? W2'(~prod_raw + W2'(1)) : prod_raw;
  assign quo_fix  = neg_lo_q ? WIDTH'(~work_q + WIDTH'(1)) : work_q;
  assign rem_fix  = neg_hi_q ? WIDTH'(~acc_q + WIDTH'(1)) : acc_q;

  // State and datapath registers; reset discards any op in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      bzero_q  <= 1'b0;
      a_raw_q  <= '0;
      b_mag_q  <= '0;
      acc_q    <= '0;
      work_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      bzero_q  <= bzero_d;
      a_raw_q  <= a_raw_d;
      b_mag_q  <= b_mag_d;
      acc_q    <= acc_d;
      work_q   <= work_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Next-state, iteration datapath and HI/LO update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    bzero_d  = bzero_q;
    a_raw_d  = a_raw_q;
    b_mag_d  = b_mag_q;
    acc_d    = acc_q;
    work_d   = work_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      S_IDLE: begin
        // MTHI/MTLO; a start in the same cycle is overwritten later at FIX
        if (wr_hi) hi_d = wr_data;
        if (wr_lo) lo_d = wr_data;
        if (start) begin
          state_d  = S_CALC;
          busy_d   = 1'b1;
          cnt_d    = '0;
          is_div_d = op[1];
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = a_neg;
          bzero_d  = (B == '0);
          a_raw_d  = A;
          b_mag_d  = b_mag;
          acc_d    = '0;
          work_d   = a_mag;
        end
      end

      S_CALC: begin
        if (is_div_q) begin
          if (!trial[WIDTH]) begin
            acc_d  = trial[WIDTH-1:0];
            work_d = {work_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d  = {acc_q[WIDTH-2:0], work_q[WIDTH-1]};
            work_d = {work_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d  = msum[WIDTH:1];
          work_d = {msum[0], work_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = S_FIX;
          cnt_d   = '0;
        end
      end

      S_FIX: begin
        if (is_div_q) begin
          if (bzero_q) begin
            hi_d = a_raw_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end else begin
          hi_d = prod_fix[W2-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table, handshake
// corner sequences, and randomized ops against an arithmetic reference.
module tb_muldiv_seq;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          reset, start, wr_hi, wr_lo;
  logic [1:0]    op;
  logic [W-1:0]  a, b, wr_data;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(a), .B(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .busy(busy), .done(done), .HI(hi), .LO(lo)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain arithmetic on the MIPS-style semantics, returns {HI,LO}
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int          xi, yi, qi, ri;
    longint      p;
    logic [63:0] r;
    xi = x;
    yi = y;
    case (o)
      2'd0: r = {32'h0, x} * {32'h0, y};
      2'd1: begin
        p = longint'(xi) * longint'(yi);
        r = 64'(p);
      end
      2'd2: begin
        if (y == 32'h0) r = {x, 32'hFFFF_FFFF};
        else            r = {x % y, x / y};
      end
      default: begin
        if (y == 32'h0) r = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else begin
          qi = xi / yi;
          ri = xi % yi;
          r  = {32'(ri), 32'(qi)};
        end
      end
    endcase
    return r;
  endfunction

  // Present one op for one edge, then scramble operands to prove they were latched
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    step();
    start = 1'b0;
    op = 2'($urandom_range(0, 3));
    a  = $urandom;
    b  = $urandom;
  endtask

  // Wait (bounded) for done; cyc counts edges after the accepting edge
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      step();
      cyc++;
    end
  endtask

  task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo);
    int cyc;
    launch(o, x, y);
    check({name, " busy"}, 64'(busy), 64'd1);
    wait_done(cyc);
    check({name, " latency"}, 64'(cyc), 64'd33);
    check({name, " HI"}, 64'(hi), 64'(ehi));
    check({name, " LO"}, 64'(lo), 64'(elo));
    check({name, " idle in done"}, 64'(busy), 64'd0);
    step();
    check({name, " done pulse"}, 64'(done), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 9))
      0: v = 32'h0;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'($urandom_range(0, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  vec_t vecs[12];

  initial begin
    int          cyc;
    logic [63:0] exp;
    logic [31:0] x, y;
    logic [1:0]  o;

    vecs[0]  = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{2'd1, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2]  = '{2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[3]  = '{2'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4]  = '{2'd2, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[5]  = '{2'd3, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
    vecs[6]  = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[7]  = '{2'd2, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[8]  = '{2'd0, 32'd6,         32'd7,         32'd0,         32'd42};
    vecs[9]  = '{2'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[10] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
    vecs[11] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

    reset = 1'b1; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    op = 2'd0; a = '0; b = '0; wr_data = '0;
    step();
    step();
    reset = 1'b0;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset HI", 64'(hi), 64'd0);
    check("reset LO", 64'(lo), 64'd0);

    // Directed table
    for (int i = 0; i < 12; i++)
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // MTHI/MTLO together in idle
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h5A5A_5A5A;
    step();
    wr_hi = 1'b0; wr_lo = 1'b0;
    check("mt HI", 64'(hi), 64'h5A5A_5A5A);
    check("mt LO", 64'(lo), 64'h5A5A_5A5A);

    // Start with MTHI in the same cycle: write lands at the accepting edge
    wr_hi = 1'b1; wr_data = 32'h1111_2222;
    op = 2'd2; a = 32'd1000; b = 32'd3; start = 1'b1;
    step();
    start = 1'b0; wr_hi = 1'b0;
    check("start+mthi HI", 64'(hi), 64'h1111_2222);
    check("start+mthi LO", 64'(lo), 64'h5A5A_5A5A);
    check("start+mthi busy", 64'(busy), 64'd1);

    // Extra starts and writes while busy must be dropped
    for (int k = 1; k <= 33; k++) begin
      start   = (k == 5 || k == 10);
      op      = 2'd0;
      a       = 32'hFFFF_FFFF;
      b       = 32'h0000_0003;
      wr_hi   = (k == 7);
      wr_lo   = (k == 7);
      wr_data = 32'hDEAD_BEEF;
      step();
      start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
      if (k == 20) begin
        check("calc HI hold", 64'(hi), 64'h1111_2222);
        check("calc LO hold", 64'(lo), 64'h5A5A_5A5A);
      end
    end
    check("busy-ignore done", 64'(done), 64'd1);
    check("busy-ignore HI", 64'(hi), 64'd1);
    check("busy-ignore LO", 64'(lo), 64'd333);

    // Back-to-back start in done cycle, with MTLO overriding the fresh LO
    wr_lo = 1'b1; wr_data = 32'hCAFE_F00D;
    launch(2'd1, 32'hFFFF_FFFD, 32'h0000_0007);
    wr_lo = 1'b0;
    check("b2b busy", 64'(busy), 64'd1);
    check("b2b done low", 64'(done), 64'd0);
    check("done-cycle mtlo LO", 64'(lo), 64'hCAFE_F00D);
    check("done-cycle mtlo HI", 64'(hi), 64'd1);
    wait_done(cyc);
    check("b2b latency", 64'(cyc), 64'd33);
    check("b2b HI", 64'(hi), 64'hFFFF_FFFF);
    check("b2b LO", 64'(lo), 64'hFFFF_FFEB);
    step();
    check("b2b done pulse", 64'(done), 64'd0);

    // Reset in the middle of CALC
    launch(2'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    for (int k = 0; k < 16; k++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    check("midreset HI", 64'(hi), 64'd0);
    check("midreset LO", 64'(lo), 64'd0);
    for (int k = 0; k < 40; k++) begin
      step();
      if (done !== 1'b0) begin
        check("midreset no stray done", 64'(done), 64'd0);
        break;
      end
    end
    do_op("post-reset multu", 2'd0, 32'd6, 32'd7, 32'd0, 32'd42);

    // Randomized ops against the reference
    for (int i = 0; i < 48; i++) begin
      o   = 2'($urandom_range(0, 3));
      x   = pick();
      y   = pick();
      exp = model(o, x, y);
      do_op($sformatf("rand%0d op%0d %h/%h", i, o, x, y), o, x, y, exp[63:32], exp[31:0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
